// File: rtl/icache_refill_responder_pkg.sv
// Shared fetch-side definitions for the I-cache refill responder: line geometry
// derived from the ICACHE_* defines and the fill FSM state type.
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef ICACHE_TAG_BITS
`define ICACHE_TAG_BITS 10
`endif
`ifndef ICACHE_INDEX_BITS
`define ICACHE_INDEX_BITS 6
`endif
`ifndef ICACHE_BLOCK_ADDR_BITS
`define ICACHE_BLOCK_ADDR_BITS 16
`endif
`ifndef ICACHE_BITS_IN_LINE
`define ICACHE_BITS_IN_LINE 256
`endif
`ifndef ICACHE_BYTES_IN_LINE_LOG
`define ICACHE_BYTES_IN_LINE_LOG 5
`endif

package icache_refill_responder_pkg;

   function automatic int beat_idx_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 0;
   endfunction

   localparam int ICACHE_PC_BITS    = `SIZE_PC;
   localparam int ICACHE_TAG_BITS   = `ICACHE_TAG_BITS;
   localparam int ICACHE_INDEX_BITS = `ICACHE_INDEX_BITS;
   localparam int ICACHE_BLOCK_BITS = `ICACHE_BLOCK_ADDR_BITS;
   localparam int ICACHE_LINE_BITS  = `ICACHE_BITS_IN_LINE;
   localparam int ICACHE_OFF_BITS   = `ICACHE_BYTES_IN_LINE_LOG;
   localparam int ICACHE_MEM_W      = 64;
   localparam int ICACHE_BEATS      = ICACHE_LINE_BITS / ICACHE_MEM_W;
   localparam int ICACHE_BEAT_W     = beat_idx_w(ICACHE_BEATS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RESP = 2'd2
   } fill_state_e;

endpackage

// File: rtl/icache_refill_responder_inv.sv
// Invalidation path: registers the cache invalidation strobe/index and flags
// invalidations that hit the block currently being filled.
module icache_refill_responder_inv #(
   parameter int PC_BITS  = 32,
   parameter int BLK_BITS = 16,
   parameter int IDX_BITS = 6,
   parameter int OFF_BITS = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inv_valid_i,
   input  logic [PC_BITS-1:0]  inv_addr_i,
   input  logic                fill_active_i,
   input  logic [BLK_BITS-1:0] fill_blk_i,
   output logic                inv_hit_o,
   output logic                inv_o,
   output logic [IDX_BITS-1:0] inv_ind_o,
   output logic                inv_way_o
);

   logic                inv_q;
   logic [IDX_BITS-1:0] inv_ind_q;
   logic [BLK_BITS-1:0] inv_blk;
   logic                unused_inv_addr;

   assign inv_blk         = inv_addr_i[BLK_BITS+OFF_BITS-1:OFF_BITS];
   // Byte offset and bits above the block field never take part in matching.
   assign unused_inv_addr = ^inv_addr_i;

   assign inv_hit_o = inv_valid_i && fill_active_i && (inv_blk == fill_blk_i);

   // NOTE: clocked state is always written with <= so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         inv_q     <= 1'b0;
         inv_ind_q <= '0;
      end else begin
         inv_q <= inv_valid_i;
         if (inv_valid_i) begin
            inv_ind_q <= inv_blk[IDX_BITS-1:0];
         end
      end
   end

   assign inv_o     = inv_q;
   assign inv_ind_o = inv_ind_q;
   assign inv_way_o = 1'b0;

endmodule

// File: rtl/icache_refill_responder.sv
// Memory-side refill responder: fetches an I-cache line as MEM_W beats, returns
// it on a one-cycle strobe, and re-fetches a fill hit by an invalidation.
module icache_refill_responder
   import icache_refill_responder_pkg::*;
#(
   parameter  int BLK_BITS  = ICACHE_BLOCK_BITS,
   parameter  int TAG_BITS  = ICACHE_TAG_BITS,
   parameter  int IDX_BITS  = ICACHE_INDEX_BITS,
   parameter  int LINE_BITS = ICACHE_LINE_BITS,
   parameter  int OFF_BITS  = ICACHE_OFF_BITS,
   parameter  int MEM_W     = ICACHE_MEM_W,
   parameter  int PC_BITS   = ICACHE_PC_BITS,
   localparam int BEATS     = LINE_BITS / MEM_W,
   localparam int BEAT_W    = beat_idx_w(BEATS),
   localparam int CNT_W     = BEAT_W + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [BLK_BITS-1:0]        ic2memReqAddr_i,
   input  logic                       ic2memReqValid_i,
   output logic [TAG_BITS-1:0]        mem2icTag_o,
   output logic [IDX_BITS-1:0]        mem2icIndex_o,
   output logic [LINE_BITS-1:0]       mem2icData_o,
   output logic                       mem2icRespValid_o,
   input  logic                       invReqValid_i,
   input  logic [PC_BITS-1:0]         invReqAddr_i,
   output logic                       mem2icInv_o,
   output logic [IDX_BITS-1:0]        mem2icInvInd_o,
   output logic                       mem2icInvWay_o,
   output logic [BLK_BITS+BEAT_W-1:0] memReqAddr_o,
   output logic                       memReqValid_o,
   input  logic                       memReqReady_i,
   input  logic [MEM_W-1:0]           memRspData_i,
   input  logic                       memRspValid_i
);

   fill_state_e          state_q, state_d;
   logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]     rcv_cnt_q, rcv_cnt_d;
   logic                 refetch_q, refetch_d;
   logic [BLK_BITS-1:0]  blk_q, blk_d;
   logic [LINE_BITS-1:0] line_q;

   logic mem_req_valid;
   logic resp_valid;
   logic rsp_take;
   logic inv_hit;

   icache_refill_responder_inv #(
      .PC_BITS  (PC_BITS),
      .BLK_BITS (BLK_BITS),
      .IDX_BITS (IDX_BITS),
      .OFF_BITS (OFF_BITS)
   ) u_inv (
      .clk           (clk),
      .reset         (reset),
      .inv_valid_i   (invReqValid_i),
      .inv_addr_i    (invReqAddr_i),
      .fill_active_i (state_q == ST_FILL),
      .fill_blk_i    (blk_q),
      .inv_hit_o     (inv_hit),
      .inv_o         (mem2icInv_o),
      .inv_ind_o     (mem2icInvInd_o),
      .inv_way_o     (mem2icInvWay_o)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch
      // can leave one unassigned and infer a latch.
      state_d       = state_q;
      issue_cnt_d   = issue_cnt_q;
      rcv_cnt_d     = rcv_cnt_q;
      refetch_d     = refetch_q;
      blk_d         = blk_q;
      mem_req_valid = 1'b0;
      resp_valid    = 1'b0;
      rsp_take      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ic2memReqValid_i) begin
               blk_d       = ic2memReqAddr_i;
               issue_cnt_d = '0;
               rcv_cnt_d   = '0;
               refetch_d   = 1'b0;
               state_d     = ST_FILL;
            end
         end

         ST_FILL: begin
            mem_req_valid = (issue_cnt_q < CNT_W'(BEATS));
            if (mem_req_valid && memReqReady_i) begin
               issue_cnt_d = issue_cnt_q + CNT_W'(1);
            end
            if (inv_hit) begin
               refetch_d = 1'b1;
            end
            if (memRspValid_i && (rcv_cnt_q < CNT_W'(BEATS))) begin
               rsp_take  = 1'b1;
               rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
               if (rcv_cnt_q == CNT_W'(BEATS - 1)) begin
                  // A hit arriving with the final beat still forces a second round.
                  if (refetch_q || inv_hit) begin
                     issue_cnt_d = '0;
                     rcv_cnt_d   = '0;
                     refetch_d   = 1'b0;
                  end else begin
                     state_d = ST_RESP;
                  end
               end
            end
         end

         ST_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= '0;
         rcv_cnt_q   <= '0;
         refetch_q   <= 1'b0;
         blk_q       <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         rcv_cnt_q   <= rcv_cnt_d;
         refetch_q   <= refetch_d;
         blk_q       <= blk_d;
      end
   end

   // NOTE: the line register is reset on purpose: the returned-data output has
   // a defined zero value out of reset, unlike a plain storage array.
   always_ff @(posedge clk) begin
      if (reset) begin
         line_q <= '0;
      end else if (rsp_take) begin
         for (int b = 0; b < BEATS; b++) begin
            if (rcv_cnt_q == CNT_W'(b)) begin
               line_q[b*MEM_W +: MEM_W] <= memRspData_i;
            end
         end
      end
   end

   if (BEAT_W > 0) begin : g_beat_field
      assign memReqAddr_o = {blk_q, issue_cnt_q[BEAT_W-1:0]};
   end else begin : g_no_beat_field
      assign memReqAddr_o = blk_q;
   end

   assign memReqValid_o     = mem_req_valid;
   assign mem2icRespValid_o = resp_valid;
   assign mem2icTag_o       = blk_q[BLK_BITS-1:IDX_BITS];
   assign mem2icIndex_o     = blk_q[IDX_BITS-1:0];
   assign mem2icData_o      = line_q;

endmodule
